mux_rr_arbiter: RTL and testbench



---
 rtl/mux_rr_arbiter_pkg.sv | 21 ++
 rtl/mux_rr_arbiter_rr_pick.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 116 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the 8:1 mux round-robin arbiter.
package mux_rr_arbiter_pkg;

  localparam int unsigned N_REQ   = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned GAP_W   = 3;

  localparam logic [SEL_W-1:0] RESET_PTR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating priority search: first set request after ptr, wrapping modulo 8.
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_idx_c,
  output logic             o_found_c
);

  logic [SEL_W-1:0] w_cand;

  // ptr itself is visited last so the previous owner has lowest priority
  always_comb begin
    o_idx_c   = '0;
    o_found_c = 1'b0;
    w_cand    = '0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      w_cand = i_ptr + SEL_W'(i);
      if (!o_found_c && i_req[w_cand]) begin
        o_idx_c   = w_cand;
        o_found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that grants one requester per burst and drives the 8:1 mux selects.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             sel2,
  output logic             sel1,
  output logic             sel0,
  output logic             busy
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic             r_busy, w_busy_nxt;
  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  rr_pick u_pick (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_idx_c   (w_idx),
    .o_found_c (w_found)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_ptr   <= RESET_PTR;
      r_sel   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // r_sel doubles as the current owner: it only moves on a new grant
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt = onehot(w_idx);
          w_sel_nxt   = w_idx;
          w_cnt_nxt   = CNT_W'(1);
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[r_sel] || (r_cnt == CNT_W'(MAX_BURST))) begin
          w_grant_nxt = '0;
          w_ptr_nxt   = r_sel;
          if (GAP_CYCLES > 0) begin
            w_gap_nxt   = GAP_W'(1);
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_GAP;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_W'(GAP_CYCLES)) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign grant = r_grant;
  assign sel2  = r_sel[2];
  assign sel1  = r_sel[1];
  assign sel0  = r_sel[0];
  assign busy  = r_busy;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_grant_matches_sel: assert property (@(posedge clk) disable iff (reset)
    (grant != '0) |-> grant[{sel2, sel1, sel0}]);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (default and MAX_BURST=1/GAP_CYCLES=0 instances).
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req0 = 8'h00;
  logic [7:0] req1 = 8'h00;
  logic [7:0] grant0, grant1;
  logic       s2a, s1a, s0a, busy0;
  logic       s2b, s1b, s0b, busy1;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .grant(grant0),
    .sel2(s2a), .sel1(s1a), .sel0(s0a), .busy(busy0)
  );

  mux_rr_arbiter #(.MAX_BURST(1), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .grant(grant1),
    .sel2(s2b), .sel1(s1b), .sel0(s0b), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic [7:0] g, input logic [2:0] s, input logic b);
    check({tag, ".grant"}, 32'(grant0), 32'(g));
    check({tag, ".sel"}, 32'({s2a, s1a, s0a}), 32'(s));
    check({tag, ".busy"}, 32'(busy0), 32'(b));
  endtask

  // leaves reset released 1ns after an edge, so the next edge is edge 1
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int owner, phase;
    logic [7:0] g;

    // reset values
    req0 = 8'h01;
    step();
    chk0("reset", 8'h00, 3'd0, 1'b0);
    check("reset.grant1", 32'(grant1), 32'h0);

    // T1: single requester, 4-cycle burst, GAP, IDLE, re-grant at edge 7
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      step();
      phase = (c - 1) % 6;
      chk0($sformatf("t1.c%0d", c), (phase < 4) ? 8'h01 : 8'h00, 3'd0, phase != 5);
    end

    // T2: requesters 0 and 7 alternate, 4 cycles each
    req0 = 8'h81;
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      step();
      phase = (c - 1) % 6;
      owner = (((c - 1) / 6) % 2 == 0) ? 0 : 7;
      g = (phase < 4) ? (8'h01 << owner) : 8'h00;
      chk0($sformatf("t2.c%0d", c), g, 3'(owner), phase != 5);
    end

    // T3: requester 3 drops after its 2nd grant cycle
    req0 = 8'h08;
    do_reset();
    step(); chk0("t3.e1", 8'h08, 3'd3, 1'b1);
    step(); chk0("t3.e2", 8'h08, 3'd3, 1'b1);
    req0 = 8'h00;
    step(); chk0("t3.rel", 8'h00, 3'd3, 1'b1);
    step(); chk0("t3.idle", 8'h00, 3'd3, 1'b0);
    step(); chk0("t3.idle2", 8'h00, 3'd3, 1'b0);

    // T4: 6 wins over 3 after 3 releases; then wrap from ptr=6 to 0
    req0 = 8'h08;
    step(); chk0("t4.g3", 8'h08, 3'd3, 1'b1);
    req0 = 8'h48;
    step(); step(); step();
    chk0("t4.g3last", 8'h08, 3'd3, 1'b1);
    step(); chk0("t4.rel3", 8'h00, 3'd3, 1'b1);
    step(); chk0("t4.idle", 8'h00, 3'd3, 1'b0);
    step(); chk0("t4.g6", 8'h40, 3'd6, 1'b1);
    req0 = 8'h09;
    step(); chk0("t4.rel6", 8'h00, 3'd6, 1'b1);
    step(); chk0("t4.idle6", 8'h00, 3'd6, 1'b0);
    step(); chk0("t4.wrap0", 8'h01, 3'd0, 1'b1);

    // T5: asynchronous reset mid-burst of owner 5
    req0 = 8'h20;
    do_reset();
    step(); chk0("t5.g5", 8'h20, 3'd5, 1'b1);
    step(); chk0("t5.cnt2", 8'h20, 3'd5, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk0("t5.async", 8'h00, 3'd0, 1'b0);
    step();
    reset = 1'b0;
    step(); chk0("t5.regrant", 8'h20, 3'd5, 1'b1);

    // T6: MAX_BURST=1, GAP_CYCLES=0, all requesting -> rotate with 1 IDLE cycle between
    req0 = 8'h00;
    req1 = 8'hFF;
    do_reset();
    for (int c = 1; c <= 18; c++) begin
      step();
      owner = ((c - 1) / 2) % 8;
      g = (c % 2 == 1) ? (8'h01 << owner) : 8'h00;
      check($sformatf("t6.c%0d.grant", c), 32'(grant1), 32'(g));
      check($sformatf("t6.c%0d.sel", c), 32'({s2b, s1b, s0b}), 32'(owner));
      check($sformatf("t6.c%0d.busy", c), 32'(busy1), 32'(c % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
